rr_logb_credit_ctrl: RTL and testbench

// - Flow-control scheduler for the packed logging-bus merge tree. The tree carries no backpressure.
// - Counts beats issued into the tree (in flight) and beats held in the downstream trace FIFO.
// - Drives logb_almful_hi/lo to the loggers with hysteresis, and sequences a flush/drain handshake.
// - Sits beside the unpack2pack tree. Its almful outputs feed the tree's almful return pipes.

---
 rtl/rr_logb_pkg.sv | 30 +++
 rtl/rr_updown_cnt.sv | 41 ++++
 rtl/rr_logb_credit_ctrl.sv | 151 +++++++++++++++
 tb/tb_rr_logb_credit_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_logb_pkg.sv
// Shared types for the logging-bus credit controller: FSM states, error bit
// positions and the state-to-almful mapping.
package rr_logb_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    NORMAL   = 3'd1,
    WARN     = 3'd2,
    STALL    = 3'd3,
    FLUSH    = 3'd4,
    ERROR    = 3'd5
  } rr_credit_state_t;

  localparam int unsigned ERR_FIFO_OF = 0;
  localparam int unsigned ERR_FIFO_UF = 1;
  localparam int unsigned ERR_INFL_UF = 2;

  // Returns {almful_hi, almful_lo} for a given state.
  function automatic logic [1:0] almful_of(input rr_credit_state_t s);
    logic [1:0] v;
    v = 2'b11;
    case (s)
      NORMAL:  v = 2'b00;
      WARN:    v = 2'b01;
      default: v = 2'b11;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_updown_cnt.sv
// Saturating up/down counter; simultaneous inc+dec holds the value, and
// over/underflow attempts are flagged for the current cycle and ignored.
module rr_updown_cnt #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf,
  output logic         o_unf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;
  logic         w_up;
  logic         w_dn;

  always_comb begin
    w_up  = i_inc && !i_dec;
    w_dn  = i_dec && !i_inc;
    o_ovf = w_up && (r_cnt == MAX_V);
    o_unf = w_dn && (r_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_up && !o_ovf) begin
      r_cnt <= r_cnt + W'(1);
    end else if (w_dn && !o_unf) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rr_logb_credit_ctrl.sv
// Credit/flow-control scheduler for the packed logging-bus merge tree: tracks
// in-flight and FIFO beats, drives almful with hysteresis, sequences flushes.
module rr_logb_credit_ctrl
  import rr_logb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned PIPE_STAGES = 8,
  parameter int unsigned HI_MARGIN   = 16,
  parameter int unsigned LO_MARGIN   = 64,
  parameter int unsigned HYST        = 8,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             issue,
  input  logic             fifo_wr,
  input  logic             fifo_rd,
  input  logic             flush_req,
  input  logic             err_clr,
  output logic             logb_almful_hi,
  output logic             logb_almful_lo,
  output logic             flush_done,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] inflight,
  output logic [2:0]       err_flags,
  output logic [2:0]       state
);

  localparam int unsigned FW = CNT_W + 2;
  localparam logic signed [FW-1:0] TH_HI      = FW'(HI_MARGIN + PIPE_STAGES);
  localparam logic signed [FW-1:0] TH_LO      = FW'(LO_MARGIN + PIPE_STAGES);
  localparam logic signed [FW-1:0] TH_HI_EXIT = FW'(HI_MARGIN + PIPE_STAGES + HYST);
  localparam logic signed [FW-1:0] TH_LO_EXIT = FW'(LO_MARGIN + PIPE_STAGES + HYST);
  localparam int unsigned INFL_MAX = (2 ** CNT_W) - 1;

  rr_credit_state_t r_state;
  rr_credit_state_t w_next;
  logic             r_hi;
  logic             r_lo;
  logic             r_done;
  logic [2:0]       r_err;

  logic             w_occ_ovf;
  logic             w_occ_unf;
  logic             w_infl_ovf;
  logic             w_infl_unf;
  logic [2:0]       w_err_evt;
  logic             w_any_err;
  logic             w_drained;
  logic             w_flush_done;
  logic signed [FW-1:0] w_free_raw;
  logic signed [FW-1:0] w_free;

  rr_updown_cnt #(
    .W   (CNT_W),
    .MAX (FIFO_DEPTH)
  ) u_occ_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (fifo_wr),
    .i_dec (fifo_rd),
    .o_cnt (occupancy),
    .o_ovf (w_occ_ovf),
    .o_unf (w_occ_unf)
  );

  rr_updown_cnt #(
    .W   (CNT_W),
    .MAX (INFL_MAX)
  ) u_infl_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (issue),
    .i_dec (fifo_wr),
    .o_cnt (inflight),
    .o_ovf (w_infl_ovf),
    .o_unf (w_infl_unf)
  );

  // In-flight saturation means beats were issued far beyond FIFO capacity,
  // so it is reported as a FIFO overflow.
  always_comb begin
    w_err_evt              = '0;
    w_err_evt[ERR_FIFO_OF] = w_occ_ovf || w_infl_ovf;
    w_err_evt[ERR_FIFO_UF] = w_occ_unf;
    w_err_evt[ERR_INFL_UF] = w_infl_unf;
    w_any_err              = |w_err_evt;
    w_drained              = (occupancy == '0) && (inflight == '0);
    w_free_raw = $signed(FW'(FIFO_DEPTH)) - $signed({2'b00, occupancy})
               - $signed({2'b00, inflight});
    w_free     = (w_free_raw < 0) ? '0 : w_free_raw;
  end

  always_comb begin
    w_next       = r_state;
    w_flush_done = 1'b0;
    if (w_any_err) begin
      w_next = ERROR;
    end else if (r_state == ERROR) begin
      if (err_clr) w_next = DISABLED;
    end else if (!en) begin
      w_next = DISABLED;
    end else if (flush_req && (r_state == NORMAL || r_state == WARN || r_state == STALL)) begin
      w_next = FLUSH;
    end else begin
      case (r_state)
        DISABLED: if (w_drained) w_next = NORMAL;
        NORMAL: begin
          if (w_free <= TH_HI)      w_next = STALL;
          else if (w_free <= TH_LO) w_next = WARN;
        end
        WARN: begin
          if (w_free <= TH_HI)           w_next = STALL;
          else if (w_free > TH_LO_EXIT)  w_next = NORMAL;
        end
        STALL: if (w_free > TH_HI_EXIT) w_next = WARN;
        FLUSH: begin
          if (w_drained) begin
            w_next       = DISABLED;
            w_flush_done = 1'b1;
          end
        end
        default: w_next = ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DISABLED;
      r_hi    <= 1'b1;
      r_lo    <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state      <= w_next;
      {r_hi, r_lo} <= almful_of(r_state);
      r_done       <= w_flush_done;
      if (w_any_err)    r_err <= r_err | w_err_evt;
      else if (err_clr) r_err <= '0;
    end
  end

  assign logb_almful_hi = r_hi;
  assign logb_almful_lo = r_lo;
  assign flush_done     = r_done;
  assign err_flags      = r_err;
  assign state          = r_state;

endmodule

// File: tb/tb_rr_logb_credit_ctrl.sv
// Scoreboard bench for rr_logb_credit_ctrl: a behavioural model pushes the
// expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_rr_logb_credit_ctrl;

  localparam int DEPTH  = 64;
  localparam int TH_HI  = 8;
  localparam int TH_LO  = 20;
  localparam int HYS    = 8;
  localparam int INFMAX = 127;
  localparam int W      = 7;

  localparam int S_DIS = 0, S_NOR = 1, S_WRN = 2, S_STL = 3, S_FLS = 4, S_ERR = 5;

  logic         clk = 1'b0;
  logic         rst, en, issue, fifo_wr, fifo_rd, flush_req, err_clr;
  logic         logb_almful_hi, logb_almful_lo, flush_done;
  logic [W-1:0] occupancy, inflight;
  logic [2:0]   err_flags, state;

  rr_logb_credit_ctrl #(
    .FIFO_DEPTH  (64),
    .PIPE_STAGES (4),
    .HI_MARGIN   (4),
    .LO_MARGIN   (16),
    .HYST        (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .issue          (issue),
    .fifo_wr        (fifo_wr),
    .fifo_rd        (fifo_rd),
    .flush_req      (flush_req),
    .err_clr        (err_clr),
    .logb_almful_hi (logb_almful_hi),
    .logb_almful_lo (logb_almful_lo),
    .flush_done     (flush_done),
    .occupancy      (occupancy),
    .inflight       (inflight),
    .err_flags      (err_flags),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, occ, infl, err;
    int hi, lo, done;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  int m_st = S_DIS, m_occ = 0, m_infl = 0, m_err = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: applies the counting, error and mode rules with integers.
  always @(posedge clk) begin
    if (rst) begin
      m_st = S_DIS; m_occ = 0; m_infl = 0; m_err = 0;
    end else begin
      int   ovf, fu, iu, evt, fr, nst, dn;
      bit   drained;
      exp_t e;
      ovf = (fifo_wr && !fifo_rd && m_occ == DEPTH) ? 1 : 0;
      fu  = (fifo_rd && !fifo_wr && m_occ == 0) ? 1 : 0;
      iu  = (fifo_wr && !issue && m_infl == 0) ? 1 : 0;
      if (issue && !fifo_wr && m_infl == INFMAX) ovf = 1;
      evt = iu * 4 + fu * 2 + ovf;
      fr  = DEPTH - m_occ - m_infl;
      if (fr < 0) fr = 0;
      drained = (m_occ == 0) && (m_infl == 0);
      nst = m_st;
      dn  = 0;
      if (evt != 0) nst = S_ERR;
      else if (m_st == S_ERR) begin
        if (err_clr) nst = S_DIS;
      end else if (!en) nst = S_DIS;
      else if (flush_req && (m_st == S_NOR || m_st == S_WRN || m_st == S_STL)) nst = S_FLS;
      else if (m_st == S_DIS) begin
        if (drained) nst = S_NOR;
      end else if (m_st == S_NOR) begin
        if (fr <= TH_HI) nst = S_STL;
        else if (fr <= TH_LO) nst = S_WRN;
      end else if (m_st == S_WRN) begin
        if (fr <= TH_HI) nst = S_STL;
        else if (fr > TH_LO + HYS) nst = S_NOR;
      end else if (m_st == S_STL) begin
        if (fr > TH_HI + HYS) nst = S_WRN;
      end else if (m_st == S_FLS) begin
        if (drained) begin nst = S_DIS; dn = 1; end
      end
      e.hi   = (m_st == S_NOR || m_st == S_WRN) ? 0 : 1;
      e.lo   = (m_st == S_NOR) ? 0 : 1;
      e.done = dn;
      if (fifo_wr && !fifo_rd && m_occ < DEPTH) m_occ++;
      else if (fifo_rd && !fifo_wr && m_occ > 0) m_occ--;
      if (issue && !fifo_wr && m_infl < INFMAX) m_infl++;
      else if (fifo_wr && !issue && m_infl > 0) m_infl--;
      if (evt != 0) m_err = m_err | evt;
      else if (err_clr) m_err = 0;
      m_st   = nst;
      e.st   = nst; e.occ = m_occ; e.infl = m_infl; e.err = m_err;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_state", int'(state), S_DIS);
      chk("rst_hi", int'(logb_almful_hi), 1);
      chk("rst_lo", int'(logb_almful_lo), 1);
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_err", int'(err_flags), 0);
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_state", int'(state), e.st);
      chk("sb_occ", int'(occupancy), e.occ);
      chk("sb_infl", int'(inflight), e.infl);
      chk("sb_err", int'(err_flags), e.err);
      chk("sb_hi", int'(logb_almful_hi), e.hi);
      chk("sb_lo", int'(logb_almful_lo), e.lo);
      chk("sb_done", int'(flush_done), e.done);
    end
  end

  task automatic step(input bit iss, input bit wr, input bit rd, input bit fl, input bit clr);
    issue = iss; fifo_wr = wr; fifo_rd = rd; flush_req = fl; err_clr = clr;
    @(posedge clk);
    #1;
    n_done += int'(flush_done);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    issue = 0; fifo_wr = 0; fifo_rd = 0; flush_req = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    en = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("en_normal", int'(state), S_NOR);
    chk("en_hi_lag", int'(logb_almful_hi), 1);
    step(0, 0, 0, 0, 0);
    chk("en_hi", int'(logb_almful_hi), 0);
    chk("en_lo", int'(logb_almful_lo), 0);

    repeat (44) step(1, 0, 0, 0, 0);
    chk("issue44_infl", int'(inflight), 44);
    step(0, 0, 0, 0, 0);
    chk("warn_state", int'(state), S_WRN);
    step(0, 0, 0, 0, 0);
    chk("warn_lo", int'(logb_almful_lo), 1);
    chk("warn_hi", int'(logb_almful_hi), 0);

    repeat (12) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("stall_state", int'(state), S_STL);
    chk("stall_hi", int'(logb_almful_hi), 1);

    repeat (56) step(0, 1, 0, 0, 0);
    chk("wr56_occ", int'(occupancy), 56);
    chk("wr56_state", int'(state), S_STL);
    repeat (9) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rd9_state", int'(state), S_WRN);
    chk("rd9_hi", int'(logb_almful_hi), 0);
    repeat (12) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rd12_state", int'(state), S_NOR);
    chk("rd12_lo", int'(logb_almful_lo), 0);

    repeat (25) step(0, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("flush_state", int'(state), S_FLS);
    step(0, 0, 0, 1, 0);
    chk("flush_hi", int'(logb_almful_hi), 1);
    chk("flush_lo", int'(logb_almful_lo), 1);
    n_done = 0;
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (13) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("flush_dis", int'(state), S_DIS);
    step(0, 0, 0, 0, 0);
    chk("flush_pulses", n_done, 1);

    step(0, 0, 1, 0, 0);
    chk("uf_err", int'(err_flags), 2);
    chk("uf_state", int'(state), S_ERR);
    step(0, 0, 0, 0, 0);
    chk("uf_hi", int'(logb_almful_hi), 1);
    step(0, 0, 0, 0, 1);
    chk("clr_state", int'(state), S_DIS);
    chk("clr_err", int'(err_flags), 0);

    step(0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      step(b, b, b, 0, 0);
    end
    chk("sim_occ", int'(occupancy), 2);
    chk("sim_infl", int'(inflight), 3);
    chk("sim_err", int'(err_flags), 0);

    for (int i = 0; i < 600; i++) begin
      bit iss, wr, rd, fl, clr;
      if ($urandom_range(0, 49) == 0) en = ~en;
      iss = 1'($urandom_range(0, 1));
      wr  = (m_infl > 0 || iss) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      if (rd && m_occ == 0) wr = 1'b0;
      fl  = ($urandom_range(0, 39) == 0);
      clr = (m_st == S_ERR) && ($urandom_range(0, 7) == 0);
      step(iss, wr, rd, fl, clr);
    end

    en = 1'b1;
    step(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(state), S_DIS);
    chk("arst_hi", int'(logb_almful_hi), 1);
    chk("arst_occ", int'(occupancy), 0);
    chk("arst_infl", int'(inflight), 0);
    chk("arst_err", int'(err_flags), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    chk("post_rst_state", int'(state), S_NOR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
